axi_lite_apb_bridge: RTL and testbench
======================================

Name: axi_lite_apb_bridge

Overview:
AXI-Lite responder that accepts read and write transactions from the existing AXI-Lite master. Each transaction is converted into a single APB3/APB4 access as the requester, and the APB result is returned as an AXI-Lite response. One transaction is outstanding at a time. The block sits between the AXI-Lite fabric and the APB peripheral subsystem.

Parameters:
ADDR_W, 32, AXI-Lite address width
DATA_W, 32, data width (AXI and APB); strobe width is DATA_W/8
APB_ADDR_W, 16, APB window width; AXI address bits above this must be zero
TIMEOUT, 255, APB wait-state limit in cycles (used only with APB_TIMEOUT_EN)

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  write strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rvalid  out  1  read response valid
s_rready  in  1  read response ready
paddr  out  APB_ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB write strobes (all zero on reads)
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Single clock domain: aclk. Reset: areset_n, asynchronous assert, active low.
- Reset values: all ready/valid outputs 0; psel, penable, pwrite 0; paddr, pwdata, pstrb, s_rdata 0; s_bresp, s_rresp OKAY; state IDLE; aw_held and w_held 0; last_grant = READ.
- AW and W channels are captured independently into holding registers.
  - s_awready = !aw_held; s_wready = !w_held. Both are valid in any state.
  - Capture happens on valid&&ready. A held flag clears when its write is dispatched.
- s_arready = 1 only in IDLE when the arbiter grants read. It may depend combinationally on s_arvalid.
- Arbitration in IDLE: a write is pending when aw_held && w_held.
  - If only one of write-pending or s_arvalid is present, grant it.
  - If both, grant the opposite of last_grant. Update last_grant on each grant.
- FSM states: IDLE, SETUP, ACCESS, WRESP, RRESP.
  - IDLE -> SETUP on grant. paddr, pwrite, pwdata and pstrb are registered from the captured transaction.
  - SETUP: psel=1, penable=0; next cycle -> ACCESS.
  - ACCESS: psel=1, penable=1; hold until pready=1.
    - On pready: latch prdata (reads) and response = pslverr ? SLVERR(2'b10) : OKAY(2'b00).
    - Drop psel/penable; go to WRESP or RRESP.
  - WRESP: s_bvalid=1 until s_bready; then -> IDLE.
  - RRESP: s_rvalid=1 with s_rdata/s_rresp stable until s_rready; then -> IDLE.
- Decode error: if the address bits [ADDR_W-1:APB_ADDR_W] are nonzero, skip the APB access. Go IDLE -> WRESP/RRESP directly with DECERR (2'b11). Read data is 0.
- Minimum latency, zero wait states, response ready already high:
  - Handshake at cycle N, SETUP at N+1, ACCESS at N+2, valid response at N+3, IDLE at N+4.
  - Decode error: valid response at N+1.
- pwdata and pstrb are held constant from SETUP through ACCESS. pstrb is forced to 0 on reads.
- Reset mid-transfer aborts immediately: psel drops, no response is issued, and held captures are discarded.
- A new AW/W pair may be captured during any state. It is dispatched only after the current response completes.

Optional Feature:
- APB_TIMEOUT_EN defined: an 8+ bit wait counter runs in ACCESS.
  - If pready has not been seen after TIMEOUT cycles in ACCESS, terminate: drop psel/penable and respond SLVERR. prdata is ignored and s_rdata=0.
  - A late pready after termination is ignored.
- Undefined: ACCESS waits indefinitely for pready, and no counter is synthesised.

Decomposition:
- axi_lite_pkg gains:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - bridge_state_t enum for the FSM states
  - localparam RESP_W=2
- One natural sub-module: axi_lite_apb_arbiter, a round-robin grant between write-pending and arvalid holding last_grant. FSM and datapath stay in the top.

Test Plan:
- Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, AW and W in same cycle, pready=1 -> APB write paddr 0x0010, pstrb 0xF; bvalid at N+3 with bresp 2'b00.
- Read 0x0000_0020, pready delayed 3 cycles, prdata 0x1234_5678, pslverr=1 -> ACCESS held 4 cycles; rdata 0x1234_5678, rresp 2'b10.
- W presented 2 cycles before AW -> wready drops after capture, no APB access until AW is accepted, then a single write.
- Write pending and arvalid in the same cycle after reset, then repeated -> first grant write, second grant read (alternation).
- Read 0x0001_0000 with APB_ADDR_W=16 -> no psel; rvalid at N+1 with rresp 2'b11, rdata 0.
- With APB_TIMEOUT_EN, TIMEOUT=8 and pready stuck at 0 -> psel drops after 8 ACCESS cycles; bresp 2'b10. Also assert areset_n low during ACCESS -> psel=0 and bvalid=0 immediately.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite to APB bridge: response codes, FSM states, grant tags.
package axi_lite_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WRESP,
    RRESP
  } bridge_state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  function automatic resp_t apb_resp(input logic slverr);
    return slverr ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_apb_arbiter.sv
// Round-robin grant between a pending write and a read request; remembers the last winner.
module axi_lite_apb_arbiter
  import axi_lite_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic grant_wr,
  output logic grant_rd
);

  grant_t last_grant_reg;
  logic   prefer_wr;

  // On a tie the side that did not win last time goes first.
  assign prefer_wr = (last_grant_reg == GRANT_READ);
  assign grant_wr  = en & wr_req & (~rd_req | prefer_wr);
  assign grant_rd  = en & rd_req & (~wr_req | ~prefer_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= GRANT_READ;
    end else if (grant_wr) begin
      last_grant_reg <= GRANT_WRITE;
    end else if (grant_rd) begin
      last_grant_reg <= GRANT_READ;
    end
  end

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// AXI-Lite responder issuing one APB access per transaction, one outstanding at a time.
// Define APB_TIMEOUT_EN to terminate APB accesses that wait longer than TIMEOUT cycles.
module axi_lite_apb_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int APB_ADDR_W = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [RESP_W-1:0]     s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [RESP_W-1:0]     s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT < 1 || APB_ADDR_W >= ADDR_W) begin : g_param_check
    $error("axi_lite_apb_bridge: need TIMEOUT >= 1 and APB_ADDR_W < ADDR_W");
  end

  bridge_state_t     state_reg;
  logic              run_reg;
  logic              aw_held_reg;
  logic              w_held_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;

  logic              aw_fire;
  logic              w_fire;
  logic              wr_pend;
  logic              idle;
  logic              grant_wr;
  logic              grant_rd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_dec_err;
  logic              rd_dec_err;

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WAIT_W-1:0] wait_cnt_reg;
`endif

  // run_reg keeps every ready low while reset is asserted.
  assign s_awready = run_reg & ~aw_held_reg;
  assign s_wready  = run_reg & ~w_held_reg;
  assign aw_fire   = s_awvalid & s_awready;
  assign w_fire    = s_wvalid & s_wready;

  // A write arriving this cycle can be dispatched straight from the inputs.
  assign wr_pend    = (aw_held_reg | aw_fire) & (w_held_reg | w_fire);
  assign wr_addr    = aw_held_reg ? awaddr_reg : s_awaddr;
  assign wr_data    = w_held_reg ? wdata_reg : s_wdata;
  assign wr_strb    = w_held_reg ? wstrb_reg : s_wstrb;
  assign wr_dec_err = |wr_addr[ADDR_W-1:APB_ADDR_W];
  assign rd_dec_err = |s_araddr[ADDR_W-1:APB_ADDR_W];

  assign idle      = run_reg & (state_reg == IDLE);
  assign s_arready = grant_rd;

  axi_lite_apb_arbiter u_arbiter (
    .clk      (aclk),
    .rst_n    (areset_n),
    .en       (idle),
    .wr_req   (wr_pend),
    .rd_req   (s_arvalid),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      if (grant_wr) begin
        aw_held_reg <= 1'b0;
      end else if (aw_fire) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= s_awaddr;
      end
      if (grant_wr) begin
        w_held_reg <= 1'b0;
      end else if (w_fire) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= s_wdata;
        wstrb_reg  <= s_wstrb;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      s_rvalid  <= 1'b0;
      s_rresp   <= OKAY;
      s_rdata   <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_wr) begin
            if (wr_dec_err) begin
              s_bresp   <= DECERR;
              s_bvalid  <= 1'b1;
              state_reg <= WRESP;
            end else begin
              paddr     <= wr_addr[APB_ADDR_W-1:0];
              pwrite    <= 1'b1;
              pwdata    <= wr_data;
              pstrb     <= wr_strb;
              psel      <= 1'b1;
              state_reg <= SETUP;
            end
          end else if (grant_rd) begin
            if (rd_dec_err) begin
              s_rdata   <= '0;
              s_rresp   <= DECERR;
              s_rvalid  <= 1'b1;
              state_reg <= RRESP;
            end else begin
              paddr     <= s_araddr[APB_ADDR_W-1:0];
              pwrite    <= 1'b0;
              pstrb     <= '0;
              psel      <= 1'b1;
              state_reg <= SETUP;
            end
          end
        end

        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pwrite) begin
              s_bresp   <= apb_resp(pslverr);
              s_bvalid  <= 1'b1;
              state_reg <= WRESP;
            end else begin
              s_rdata   <= prdata;
              s_rresp   <= apb_resp(pslverr);
              s_rvalid  <= 1'b1;
              state_reg <= RRESP;
            end
          end
`ifdef APB_TIMEOUT_EN
          // Last permitted ACCESS cycle without pready: abandon the peripheral.
          else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pwrite) begin
              s_bresp   <= SLVERR;
              s_bvalid  <= 1'b1;
              state_reg <= WRESP;
            end else begin
              s_rdata   <= '0;
              s_rresp   <= SLVERR;
              s_rvalid  <= 1'b1;
              state_reg <= RRESP;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        WRESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        RRESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed bench for axi_lite_apb_bridge with a small APB responder and one check task.
module tb_axi_lite_apb_bridge;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int tests_run    = 0;
  int tests_failed = 0;

  // APB responder: pready after wait_states ACCESS cycles
  int          wait_states = 0;
  int          acc_cnt     = 0;
  int          apb_xfers   = 0;
  int          access_cyc  = 0;
  logic [15:0] last_paddr  = '0;
  logic [31:0] last_pwdata = '0;
  logic [3:0]  last_pstrb  = '0;
  logic        last_pwrite = 1'b0;

  assign pready = psel && penable && (acc_cnt >= wait_states);

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (psel && !penable) begin
      apb_xfers   <= apb_xfers + 1;
      last_paddr  <= paddr;
      last_pwdata <= pwdata;
      last_pstrb  <= pstrb;
      last_pwrite <= pwrite;
    end
    if (psel && penable) access_cyc <= access_cyc + 1;
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  axi_lite_apb_bridge #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .APB_ADDR_W (16),
    .TIMEOUT    (8)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_b(output int lat);
    lat = 1;
    while (!s_bvalid && lat < 40) begin
      tick();
      lat++;
    end
    if (!s_bvalid) check("bvalid_wait_expired", 64'(s_bvalid), 64'd1);
    $display("[TB] write done: bresp=%0d latency=%0d", s_bresp, lat);
  endtask

  task automatic wait_r(output int lat);
    lat = 1;
    while (!s_rvalid && lat < 40) begin
      tick();
      lat++;
    end
    if (!s_rvalid) check("rvalid_wait_expired", 64'(s_rvalid), 64'd1);
    $display("[TB] read done: rdata=0x%08h rresp=%0d latency=%0d", s_rdata, s_rresp, lat);
  endtask

  task automatic do_reset();
    areset_n  = 1'b0;
    s_awaddr  = '0; s_awvalid = 1'b0;
    s_wdata   = '0; s_wstrb   = '0; s_wvalid = 1'b0;
    s_araddr  = '0; s_arvalid = 1'b1;
    s_bready  = 1'b0; s_rready = 1'b0;
    prdata    = '0; pslverr   = 1'b0; wait_states = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_rdata", 64'(s_rdata), 64'd0);
    s_arvalid = 1'b0;
    areset_n  = 1'b1;
    tick();
    tick();
  endtask

  int lat;
  int base;

  initial begin
    do_reset();

    // Write 0x10, AW and W together, zero wait states
    s_bready = 1'b1;
    s_awaddr = 32'h0000_0010; s_awvalid = 1'b1;
    s_wdata  = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    #1;
    check("wr1_awready", 64'(s_awready), 64'd1);
    check("wr1_wready", 64'(s_wready), 64'd1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("wr1_setup_psel", 64'(psel), 64'd1);
    check("wr1_setup_penable", 64'(penable), 64'd0);
    wait_b(lat);
    check("wr1_latency", 64'(lat), 64'd3);
    check("wr1_bresp", 64'(s_bresp), 64'd0);
    check("wr1_paddr", 64'(last_paddr), 64'h0010);
    check("wr1_pwdata", 64'(last_pwdata), 64'hDEAD_BEEF);
    check("wr1_pstrb", 64'(last_pstrb), 64'hF);
    check("wr1_pwrite", 64'(last_pwrite), 64'd1);
    tick();
    check("wr1_bvalid_clear", 64'(s_bvalid), 64'd0);

    // Read 0x20, three wait states, slave error
    base = access_cyc;
    wait_states = 3; prdata = 32'h1234_5678; pslverr = 1'b1;
    s_araddr = 32'h0000_0020; s_arvalid = 1'b1;
    #1;
    check("rd1_arready", 64'(s_arready), 64'd1);
    tick();
    s_arvalid = 1'b0;
    wait_r(lat);
    check("rd1_latency", 64'(lat), 64'd6);
    check("rd1_access_cycles", 64'(access_cyc - base), 64'd4);
    check("rd1_rdata", 64'(s_rdata), 64'h1234_5678);
    check("rd1_rresp", 64'(s_rresp), 64'd2);
    check("rd1_pstrb", 64'(last_pstrb), 64'd0);
    check("rd1_pwrite", 64'(last_pwrite), 64'd0);
    prdata = 32'h0; pslverr = 1'b0;
    tick();
    check("rd1_rvalid_hold", 64'(s_rvalid), 64'd1);
    check("rd1_rdata_hold", 64'(s_rdata), 64'h1234_5678);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check("rd1_rvalid_clear", 64'(s_rvalid), 64'd0);
    wait_states = 0;

    // W two cycles ahead of AW
    base = apb_xfers;
    s_wdata = 32'hA5A5_0001; s_wstrb = 4'h3; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    check("wfirst_wready_low", 64'(s_wready), 64'd0);
    tick();
    check("wfirst_no_apb", 64'(apb_xfers - base), 64'd0);
    check("wfirst_psel_idle", 64'(psel), 64'd0);
    s_awaddr = 32'h0000_0044; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    wait_b(lat);
    check("wfirst_latency", 64'(lat), 64'd3);
    check("wfirst_xfers", 64'(apb_xfers - base), 64'd1);
    check("wfirst_paddr", 64'(last_paddr), 64'h0044);
    check("wfirst_pwdata", 64'(last_pwdata), 64'hA5A5_0001);
    check("wfirst_pstrb", 64'(last_pstrb), 64'h3);
    check("wfirst_wready_back", 64'(s_wready), 64'd1);
    tick();

    // Arbitration from reset: write first, then read wins the next tie
    do_reset();
    s_bready = 1'b1; s_rready = 1'b1; prdata = 32'hCAFE_0001;
    s_awaddr = 32'h0000_0100; s_awvalid = 1'b1;
    s_wdata  = 32'h1111_1111; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 32'h0000_0200; s_arvalid = 1'b1;
    #1;
    check("arb1_read_waits", 64'(s_arready), 64'd0);
    tick();
    check("arb1_write_granted", 64'(last_pwrite | (psel & pwrite)), 64'd1);
    s_awaddr = 32'h0000_0104; s_wdata = 32'h2222_2222;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("arb_held_awready", 64'(s_awready), 64'd0);
    wait_b(lat);
    check("arb1_paddr", 64'(last_paddr), 64'h0100);
    tick();
    check("arb2_read_granted", 64'(s_arready), 64'd1);
    tick();
    s_arvalid = 1'b0;
    wait_r(lat);
    check("arb2_paddr", 64'(last_paddr), 64'h0200);
    check("arb2_rdata", 64'(s_rdata), 64'hCAFE_0001);
    tick();
    wait_b(lat);
    check("arb3_paddr", 64'(last_paddr), 64'h0104);
    check("arb3_pwdata", 64'(last_pwdata), 64'h2222_2222);
    tick();
    s_rready = 1'b0;

    // Decode errors: no APB access, response one cycle after handshake
    base = apb_xfers;
    s_araddr = 32'h0001_0000; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    wait_r(lat);
    check("dec_rd_latency", 64'(lat), 64'd1);
    check("dec_rd_rresp", 64'(s_rresp), 64'd3);
    check("dec_rd_rdata", 64'(s_rdata), 64'd0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    s_awaddr = 32'h8000_0000; s_awvalid = 1'b1;
    s_wdata  = 32'h5555_5555; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b(lat);
    check("dec_wr_latency", 64'(lat), 64'd1);
    check("dec_wr_bresp", 64'(s_bresp), 64'd3);
    check("dec_no_apb", 64'(apb_xfers - base), 64'd0);
    tick();

`ifdef APB_TIMEOUT_EN
    // pready never arrives: terminated after 8 ACCESS cycles
    base = access_cyc;
    wait_states = 1000;
    s_awaddr = 32'h0000_0040; s_awvalid = 1'b1;
    s_wdata  = 32'h0BAD_0BAD; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b(lat);
    check("tmo_latency", 64'(lat), 64'd10);
    check("tmo_access_cycles", 64'(access_cyc - base), 64'd8);
    check("tmo_bresp", 64'(s_bresp), 64'd2);
    check("tmo_psel_dropped", 64'(psel), 64'd0);
    tick();
    wait_states = 0;
`endif

    // Reset during ACCESS aborts the transfer and drops a held W
    wait_states = 1000;
    s_awaddr = 32'h0000_0030; s_awvalid = 1'b1;
    s_wdata  = 32'h7777_0000; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    s_wdata = 32'h8888_0000; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    check("abort_access_penable", 64'(penable), 64'd1);
    check("abort_w_held", 64'(s_wready), 64'd0);
    #2;
    areset_n = 1'b0;
    #1;
    check("abort_psel", 64'(psel), 64'd0);
    check("abort_penable", 64'(penable), 64'd0);
    check("abort_bvalid", 64'(s_bvalid), 64'd0);
    tick();
    areset_n = 1'b1;
    wait_states = 0;
    base = apb_xfers;
    repeat (3) tick();
    check("abort_wready_back", 64'(s_wready), 64'd1);
    check("abort_no_response", 64'(s_bvalid), 64'd0);
    check("abort_no_apb", 64'(apb_xfers - base), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
